// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-subset 5-stage core.
// Holds datapath widths, ALU execute-command encodings, NZCV bit indices and the
// ID/EXE control bundle that a flush clears as one group.
package arm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CMD_W  = 4;

  // ALU execute commands; NOP must stay zero so a cleared control group is a NOP.
  localparam logic [CMD_W-1:0] EXE_NOP = 4'h0;
  localparam logic [CMD_W-1:0] EXE_MOV = 4'h1;
  localparam logic [CMD_W-1:0] EXE_ADD = 4'h2;
  localparam logic [CMD_W-1:0] EXE_ADC = 4'h3;
  localparam logic [CMD_W-1:0] EXE_SUB = 4'h4;
  localparam logic [CMD_W-1:0] EXE_SBC = 4'h5;
  localparam logic [CMD_W-1:0] EXE_AND = 4'h6;
  localparam logic [CMD_W-1:0] EXE_ORR = 4'h7;
  localparam logic [CMD_W-1:0] EXE_EOR = 4'h8;
  localparam logic [CMD_W-1:0] EXE_MVN = 4'h9;

  // Bit positions inside the 4-bit status word.
  localparam int unsigned N = 3;
  localparam int unsigned Z = 2;
  localparam int unsigned C = 1;
  localparam int unsigned V = 0;

  // Side-effecting control carried from ID to EXE.
  typedef struct packed {
    logic             mem_r;
    logic             mem_w;
    logic             wb_en;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
  } id_exe_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register.
// Ports:
//   clk_i  - rising-edge clock
//   rst_i  - synchronous active-high reset (highest priority, clears to 0)
//   clr_i  - synchronous clear to 0 (beats en_i)
//   en_i   - load d_i; when low the register holds
//   d_i    - next value
//   q_o    - registered value
module pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register of the ARM-subset 5-stage core.
// Captures decoded operands and control each cycle with one cycle of latency.
// Ports:
//   clk, rst (sync, active-high), freeze (hold everything), flush (insert bubble)
//   id_*   - decoded instruction fields from the ID stage
//   exe_*  - registered copies presented to the EXE stage
//   exe_valid         - stage holds a real instruction
//   exe_is_ldr_or_str - registered id_mem_r | id_mem_w
//   bubble_count      - saturating count of bubbles entered
// Priority at each edge: rst > flush > freeze > load. All outputs come from flops.
module id_exe_stage_reg #(
  parameter int unsigned DATA_W = arm_pkg::DATA_W,
  parameter int unsigned ADDR_W = arm_pkg::ADDR_W,
  parameter int unsigned CMD_W  = arm_pkg::CMD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val_rn,
  input  logic [DATA_W-1:0] id_val_rm,
  input  logic              id_imm,
  input  logic [11:0]       id_shift_operand,
  input  logic [23:0]       id_signed_imm_24,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic [CMD_W-1:0]  id_exe_cmd,
  input  logic              id_mem_r,
  input  logic              id_mem_w,
  input  logic              id_wb_en,
  input  logic              id_b,
  input  logic              id_s,
  input  logic [3:0]        id_status,
  output logic [DATA_W-1:0] exe_pc,
  output logic [DATA_W-1:0] exe_val_rn,
  output logic [DATA_W-1:0] exe_val_rm,
  output logic              exe_imm,
  output logic [11:0]       exe_shift_operand,
  output logic [23:0]       exe_signed_imm_24,
  output logic [ADDR_W-1:0] exe_dest,
  output logic [ADDR_W-1:0] exe_src1,
  output logic [ADDR_W-1:0] exe_src2,
  output logic [CMD_W-1:0]  exe_exe_cmd,
  output logic              exe_mem_r,
  output logic              exe_mem_w,
  output logic              exe_wb_en,
  output logic              exe_b,
  output logic              exe_s,
  output logic [3:0]        exe_status,
  output logic              exe_valid,
  output logic              exe_is_ldr_or_str,
  output logic [15:0]       bubble_count
);

  import arm_pkg::*;

  // Control group: valid, is_ldr_or_str and the side-effecting control bundle.
  localparam int unsigned CtrlW = $bits(id_exe_ctrl_t) + 2;
  // Data group: everything a flush may load freely.
  localparam int unsigned DataW = 3 * DATA_W + 1 + 12 + 24 + 3 * ADDR_W + 4;

  id_exe_ctrl_t     ctrl_in, ctrl_out;
  logic [CtrlW-1:0] ctrl_vec_in, ctrl_vec_out;
  logic [DataW-1:0] data_vec_in, data_vec_out;
  logic             ctrl_valid_out, ctrl_ls_out;

  always_comb begin
    ctrl_in         = '0;
    ctrl_in.mem_r   = id_mem_r;
    ctrl_in.mem_w   = id_mem_w;
    ctrl_in.wb_en   = id_wb_en;
    ctrl_in.b       = id_b;
    ctrl_in.s       = id_s;
    ctrl_in.exe_cmd = id_exe_cmd;
  end

  assign ctrl_vec_in = {id_valid, id_mem_r | id_mem_w, ctrl_in};
  assign data_vec_in = {id_pc, id_val_rn, id_val_rm, id_imm, id_shift_operand,
                        id_signed_imm_24, id_dest, id_src1, id_src2, id_status};

  // Flush clears control outright, so freeze only matters for the control enable.
  pipe_reg #(
    .Width (CtrlW)
  ) u_ctrl_reg (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (flush),
    .en_i  (~freeze),
    .d_i   (ctrl_vec_in),
    .q_o   (ctrl_vec_out)
  );

  // Datapath still loads on a flush (contents are don't-care but deterministic).
  pipe_reg #(
    .Width (DataW)
  ) u_data_reg (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (1'b0),
    .en_i  (~freeze | flush),
    .d_i   (data_vec_in),
    .q_o   (data_vec_out)
  );

  assign {ctrl_valid_out, ctrl_ls_out, ctrl_out} = ctrl_vec_out;
  assign {exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand,
          exe_signed_imm_24, exe_dest, exe_src1, exe_src2, exe_status} = data_vec_out;

  assign exe_valid         = ctrl_valid_out;
  assign exe_is_ldr_or_str = ctrl_ls_out;
  assign exe_mem_r         = ctrl_out.mem_r;
  assign exe_mem_w         = ctrl_out.mem_w;
  assign exe_wb_en         = ctrl_out.wb_en;
  assign exe_b             = ctrl_out.b;
  assign exe_s             = ctrl_out.s;
  assign exe_exe_cmd       = ctrl_out.exe_cmd;

  // A bubble enters when the stage updates (flush or load) with exe_valid ending at 0.
  logic        bubble_edge;
  logic [15:0] bubble_count_d, bubble_count_q;

  always_comb begin
    bubble_edge    = flush | (~freeze & ~id_valid);
    bubble_count_d = bubble_count_q;
    if (bubble_edge && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, id_valid;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic        id_imm;
  logic [11:0] id_shift_operand;
  logic [23:0] id_signed_imm_24;
  logic [3:0]  id_dest, id_src1, id_src2, id_exe_cmd, id_status;
  logic        id_mem_r, id_mem_w, id_wb_en, id_b, id_s;

  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic        exe_imm;
  logic [11:0] exe_shift_operand;
  logic [23:0] exe_signed_imm_24;
  logic [3:0]  exe_dest, exe_src1, exe_src2, exe_exe_cmd, exe_status;
  logic        exe_mem_r, exe_mem_w, exe_wb_en, exe_b, exe_s, exe_valid, exe_is_ldr_or_str;
  logic [15:0] bubble_count;

  int errors = 0;
  int checks = 0;

  id_exe_stage_reg dut (
    .clk               (clk),
    .rst               (rst),
    .freeze            (freeze),
    .flush             (flush),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_val_rn         (id_val_rn),
    .id_val_rm         (id_val_rm),
    .id_imm            (id_imm),
    .id_shift_operand  (id_shift_operand),
    .id_signed_imm_24  (id_signed_imm_24),
    .id_dest           (id_dest),
    .id_src1           (id_src1),
    .id_src2           (id_src2),
    .id_exe_cmd        (id_exe_cmd),
    .id_mem_r          (id_mem_r),
    .id_mem_w          (id_mem_w),
    .id_wb_en          (id_wb_en),
    .id_b              (id_b),
    .id_s              (id_s),
    .id_status         (id_status),
    .exe_pc            (exe_pc),
    .exe_val_rn        (exe_val_rn),
    .exe_val_rm        (exe_val_rm),
    .exe_imm           (exe_imm),
    .exe_shift_operand (exe_shift_operand),
    .exe_signed_imm_24 (exe_signed_imm_24),
    .exe_dest          (exe_dest),
    .exe_src1          (exe_src1),
    .exe_src2          (exe_src2),
    .exe_exe_cmd       (exe_exe_cmd),
    .exe_mem_r         (exe_mem_r),
    .exe_mem_w         (exe_mem_w),
    .exe_wb_en         (exe_wb_en),
    .exe_b             (exe_b),
    .exe_s             (exe_s),
    .exe_status        (exe_status),
    .exe_valid         (exe_valid),
    .exe_is_ldr_or_str (exe_is_ldr_or_str),
    .bubble_count      (bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage as a record of what EXE should see.
  typedef struct {
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, s1, s2, cmd, st;
    logic        mem_r, mem_w, wb, b, s, valid, ls;
    int          cnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];

  always @(posedge clk) begin
    if (rst) begin
      m = '{default: '0};
    end else if (flush || !freeze) begin
      m.pc = id_pc; m.rn = id_val_rn; m.rm = id_val_rm; m.imm = id_imm;
      m.sh = id_shift_operand; m.si = id_signed_imm_24; m.dest = id_dest;
      m.s1 = id_src1; m.s2 = id_src2; m.st = id_status;
      // A flushed instruction is dead: no memory, writeback, branch or flag effect.
      m.valid = flush ? 1'b0 : id_valid;
      m.mem_r = flush ? 1'b0 : id_mem_r;
      m.mem_w = flush ? 1'b0 : id_mem_w;
      m.wb    = flush ? 1'b0 : id_wb_en;
      m.b     = flush ? 1'b0 : id_b;
      m.s     = flush ? 1'b0 : id_s;
      m.cmd   = flush ? 4'h0 : id_exe_cmd;
      m.ls    = m.mem_r | m.mem_w;
      if (!m.valid) m.cnt = (m.cnt >= 65535) ? 65535 : m.cnt + 1;
    end
    sb.push_back(m);
  end

  // Monitor: the stage presents a new state every edge; compare it to the model.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc", exe_pc, e.pc);
      chk("val_rn", exe_val_rn, e.rn);
      chk("val_rm", exe_val_rm, e.rm);
      chk("imm", 32'(exe_imm), 32'(e.imm));
      chk("shift_operand", 32'(exe_shift_operand), 32'(e.sh));
      chk("signed_imm_24", 32'(exe_signed_imm_24), 32'(e.si));
      chk("dest", 32'(exe_dest), 32'(e.dest));
      chk("src1", 32'(exe_src1), 32'(e.s1));
      chk("src2", 32'(exe_src2), 32'(e.s2));
      chk("exe_cmd", 32'(exe_exe_cmd), 32'(e.cmd));
      chk("status", 32'(exe_status), 32'(e.st));
      chk("mem_r", 32'(exe_mem_r), 32'(e.mem_r));
      chk("mem_w", 32'(exe_mem_w), 32'(e.mem_w));
      chk("wb_en", 32'(exe_wb_en), 32'(e.wb));
      chk("b", 32'(exe_b), 32'(e.b));
      chk("s", 32'(exe_s), 32'(e.s));
      chk("valid", 32'(exe_valid), 32'(e.valid));
      chk("is_ldr_or_str", 32'(exe_is_ldr_or_str), 32'(e.ls));
      chk("bubble_count", 32'(bubble_count), e.cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] v);
    id_pc = v; id_val_rn = v; id_val_rm = v; id_imm = v[0];
    id_shift_operand = v[11:0]; id_signed_imm_24 = v[23:0];
    id_dest = v[3:0]; id_src1 = v[3:0]; id_src2 = v[3:0]; id_exe_cmd = v[3:0];
    id_status = v[3:0]; id_mem_r = v[0]; id_mem_w = v[0]; id_wb_en = v[0];
    id_b = v[0]; id_s = v[0]; id_valid = v[0];
  endtask

  task automatic rand_id();
    id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
    id_imm = 1'($urandom); id_shift_operand = 12'($urandom);
    id_signed_imm_24 = 24'($urandom); id_dest = 4'($urandom);
    id_src1 = 4'($urandom); id_src2 = 4'($urandom); id_exe_cmd = 4'($urandom);
    id_status = 4'($urandom); id_mem_r = 1'($urandom); id_mem_w = 1'($urandom);
    id_wb_en = 1'($urandom); id_b = 1'($urandom); id_s = 1'($urandom);
    id_valid = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    set_id(32'hFFFF_FFFF);
    tick(); tick();
    chk("rst_pc", exe_pc, 32'h0);
    chk("rst_valid", 32'(exe_valid), 32'h0);
    chk("rst_wb_en", 32'(exe_wb_en), 32'h0);
    chk("rst_count", 32'(bubble_count), 32'h0);

    rst = 1'b0;
    set_id(32'h0);
    id_pc = 32'h0000_0008; id_val_rm = 32'h8000_0001; id_shift_operand = 12'h0E3;
    id_imm = 1'b0; id_valid = 1'b1;
    tick();
    chk("first_val_rm", exe_val_rm, 32'h8000_0001);
    chk("first_shift", 32'(exe_shift_operand), 32'h0E3);
    chk("first_valid", 32'(exe_valid), 32'h1);

    // LDR then STR.
    id_mem_r = 1'b1; id_wb_en = 1'b1; id_shift_operand = 12'h804;
    tick();
    chk("ldr_ls", 32'(exe_is_ldr_or_str), 32'h1);
    chk("ldr_wb", 32'(exe_wb_en), 32'h1);
    id_mem_r = 1'b0; id_mem_w = 1'b1; id_wb_en = 1'b0;
    tick();
    chk("str_ls", 32'(exe_is_ldr_or_str), 32'h1);
    chk("str_wb", 32'(exe_wb_en), 32'h0);

    // Freeze while ID churns: STR must stay put.
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      chk("frz_shift", 32'(exe_shift_operand), 32'h804);
      chk("frz_mem_w", 32'(exe_mem_w), 32'h1);
      chk("frz_count", 32'(bubble_count), 32'h0);
    end

    // Flush beats freeze.
    flush = 1'b1; id_valid = 1'b1; id_wb_en = 1'b1; id_b = 1'b1; id_exe_cmd = 4'h2;
    tick();
    chk("fl_wb", 32'(exe_wb_en), 32'h0);
    chk("fl_b", 32'(exe_b), 32'h0);
    chk("fl_cmd", 32'(exe_exe_cmd), 32'h0);
    chk("fl_valid", 32'(exe_valid), 32'h0);
    chk("fl_count", 32'(bubble_count), 32'h1);
    flush = 1'b0; freeze = 1'b0;

    // Five loaded bubbles from zero.
    rst = 1'b1; tick(); rst = 1'b0;
    id_valid = 1'b0;
    repeat (5) tick();
    chk("bub5", 32'(bubble_count), 32'h5);

    // Random mix of every control combination.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rst    = ($urandom_range(0, 49) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; freeze = 1'b0;

    // Reset in the middle of a stall.
    set_id(32'h0);
    id_valid = 1'b1; id_wb_en = 1'b1; id_exe_cmd = arm_pkg::EXE_ADD; id_pc = 32'h40;
    tick();
    chk("add_wb", 32'(exe_wb_en), 32'h1);
    freeze = 1'b1; rst = 1'b1;
    tick();
    chk("rstfrz_wb", 32'(exe_wb_en), 32'h0);
    chk("rstfrz_pc", exe_pc, 32'h0);
    chk("rstfrz_valid", 32'(exe_valid), 32'h0);
    rst = 1'b0;
    tick(); tick();
    chk("postrst_wb", 32'(exe_wb_en), 32'h0);
    chk("postrst_cmd", 32'(exe_exe_cmd), 32'h0);

    // Saturation.
    freeze = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    id_valid = 1'b0;
    repeat (65534) tick();
    chk("sat_fffe", 32'(bubble_count), 32'hFFFE);
    repeat (3) tick();
    chk("sat_ffff", 32'(bubble_count), 32'hFFFF);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the ID stage and the EXE stage of the ARM-subset 5-stage core.
- Captures decoded operands and control each cycle.
- Presents registered operand fields directly to the EXE-stage second-operand generator (Val_Rm, imm, Shift_operand, is_ldr_or_str) and the ALU.
- Supports freeze (hazard stall), flush (taken branch) and a valid bit that marks bubbles.

Parameters:
- DATA_W, 32, width of register values and PC.
- ADDR_W, 4, register-file address width.
- CMD_W, 4, ALU execute-command width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hold all stored state (hazard stall).
- flush  in  1  replace the incoming instruction with a bubble.
- id_valid  in  1  ID stage holds a real instruction.
- id_pc  in  DATA_W  PC+4 of the instruction.
- id_val_rn  in  DATA_W  register-file read of Rn.
- id_val_rm  in  DATA_W  register-file read of Rm.
- id_imm  in  1  I bit.
- id_shift_operand  in  12  shifter_operand / offset_12.
- id_signed_imm_24  in  24  branch offset.
- id_dest  in  ADDR_W  destination register.
- id_src1, id_src2  in  ADDR_W  Rn / Rm addresses, for forwarding.
- id_exe_cmd  in  CMD_W  ALU command.
- id_mem_r, id_mem_w, id_wb_en, id_b, id_s  in  1 each  control bits.
- id_status  in  4  NZCV captured at decode.
- exe_* (one per id_* above, same widths)  out  registered copies.
- exe_valid  out  1  stage holds a real instruction.
- exe_is_ldr_or_str  out  1  registered (id_mem_r | id_mem_w).
- bubble_count  out  16  number of bubbles entered.

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at posedge):
  - All exe_* outputs, exe_valid and exe_is_ldr_or_str go to 0.
  - bubble_count goes to 0.
  - rst has priority over flush and freeze.
  - rst asserted mid-stall clears state on that edge regardless of freeze.
- Latency: exactly 1 cycle. ID values at posedge N appear on exe_* after posedge N.
- Priority at each posedge: rst > flush > freeze > load.
- Load (no rst/flush/freeze):
  - Every exe_* takes its id_* value.
  - exe_valid = id_valid.
  - exe_is_ldr_or_str = id_mem_r | id_mem_w.
- Flush:
  - Clears the side-effecting control: exe_valid, exe_mem_r, exe_mem_w, exe_wb_en, exe_b, exe_s and exe_is_ldr_or_str all go to 0.
  - exe_exe_cmd goes to 0.
  - Datapath fields (pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2, status) load normally; their contents are don't-care but deterministic.
  - Flush wins over simultaneous freeze; a flush during a stall still kills the held instruction.
- Freeze (no flush): every register, including bubble_count, holds its value.
- Bubble definition: an edge where the stage is loaded or flushed and the resulting exe_valid=0. This includes a load with id_valid=0.
- bubble_count:
  - Increments by 1 on each bubble edge.
  - Saturates at 16'hFFFF; no wrap.
  - Does not count freeze edges.
- No combinational paths from inputs to outputs; all outputs come straight from flops.
- Invariant: exe_is_ldr_or_str is always equal to exe_mem_r | exe_mem_w.
- The stage performs no sign extension or shifting; the EXE stage owns Val2 generation.

Decomposition:
- Shared package `arm_pkg` holds:
  - DATA_W, ADDR_W, CMD_W.
  - ALU command encodings (EXE_MOV, EXE_ADD, ..., EXE_NOP=0).
  - The status-bit index constants N=3, Z=2, C=1, V=0.
  - A packed struct `id_exe_ctrl_t` (mem_r, mem_w, wb_en, b, s, exe_cmd) so that flush clears one field group.
- Sub-module `pipe_reg`: generic width-parameterised register with rst, clr and en. Instantiate it twice:
  - Control group: clr = flush.
  - Data group: clr tied low.
- The bubble counter stays inline.

Test Plan:
- Reset with all id_* = 1s, then release and apply id_pc=32'h0000_0008, id_val_rm=32'h8000_0001, id_shift_operand=12'h0E3, id_imm=0 -> all exe_* = 0 during rst; one edge after release exe_val_rm=32'h8000_0001, exe_shift_operand=12'h0E3, exe_valid=1.
- LDR (id_mem_r=1, id_wb_en=1, id_shift_operand=12'h804) then STR (id_mem_w=1) on consecutive cycles -> exe_is_ldr_or_str=1 on both; exe_wb_en 1 then 0.
- freeze=1 for 3 cycles while id_* changes every cycle -> exe_* hold the pre-freeze instruction; bubble_count unchanged.
- flush=1 and freeze=1 together with id_wb_en=1, id_b=1, id_exe_cmd=4'h2 -> next cycle exe_wb_en=0, exe_b=0, exe_exe_cmd=0, exe_valid=0; bubble_count +1.
- id_valid=0 for 5 loaded cycles from bubble_count=0 -> bubble_count=5. Preload bubble_count to 16'hFFFE via repeated bubbles, then 3 more -> stays 16'hFFFF.
- rst asserted during freeze with a held ADD (exe_wb_en=1) -> next edge all outputs 0. After release with freeze still 1 -> outputs remain 0.
